// File: rtl/memwb_skid_stage_if.sv
// memwb_skid_stage_if
//   Handshake and payload bundle for the MEM/WB skid stage. Signal names are
//   given from the stage's point of view: i_* flow into the stage, o_* flow
//   out of it.
//   Modports:
//     slave  - the stage itself (consumes i_*, drives o_*)
//     master - the environment around the stage (drives i_*, consumes o_*)
//   Signals:
//     i_flush                        synchronous flush of all held entries
//     i_valid / o_ready              upstream handshake
//     i_data_pc4, i_data_alures,     memory-stage payload
//     i_data_memout, i_addr_regdst,
//     i_addr_Mrt, i_con_*
//     o_valid / i_ready              downstream handshake
//     o_data_*, o_addr_*, o_con_*    writeback payload
//     o_stall_cnt                    saturating back-pressure counter
interface memwb_skid_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned LMUX_W = 2,
  parameter int unsigned CNT_W  = 16
);
  logic              i_flush;
  logic              i_valid;
  logic              o_ready;
  logic [DATA_W-1:0] i_data_pc4;
  logic [DATA_W-1:0] i_data_alures;
  logic [DATA_W-1:0] i_data_memout;
  logic [RA_W-1:0]   i_addr_regdst;
  logic [RA_W-1:0]   i_addr_Mrt;
  logic [LMUX_W-1:0] i_con_Wloadmux;
  logic              i_con_Walupc8;
  logic              i_con_Wmemtoreg;
  logic              i_con_Wregwrite;
  logic              i_con_FWmemread;

  logic              o_valid;
  logic              i_ready;
  logic [DATA_W-1:0] o_data_pc8;
  logic [DATA_W-1:0] o_data_alures;
  logic [DATA_W-1:0] o_data_memout;
  logic [RA_W-1:0]   o_addr_regdst;
  logic [RA_W-1:0]   o_addr_Wrt;
  logic [LMUX_W-1:0] o_con_Wloadmux;
  logic              o_con_Walupc8;
  logic              o_con_Wmemtoreg;
  logic              o_con_Wregwrite;
  logic              o_con_FWmemread;
  logic [CNT_W-1:0]  o_stall_cnt;

  modport slave (
    input  i_flush, i_valid, i_data_pc4, i_data_alures, i_data_memout, i_addr_regdst,
           i_addr_Mrt, i_con_Wloadmux, i_con_Walupc8, i_con_Wmemtoreg, i_con_Wregwrite,
           i_con_FWmemread, i_ready,
    output o_ready, o_valid, o_data_pc8, o_data_alures, o_data_memout, o_addr_regdst,
           o_addr_Wrt, o_con_Wloadmux, o_con_Walupc8, o_con_Wmemtoreg, o_con_Wregwrite,
           o_con_FWmemread, o_stall_cnt
  );

  modport master (
    output i_flush, i_valid, i_data_pc4, i_data_alures, i_data_memout, i_addr_regdst,
           i_addr_Mrt, i_con_Wloadmux, i_con_Walupc8, i_con_Wmemtoreg, i_con_Wregwrite,
           i_con_FWmemread, i_ready,
    input  o_ready, o_valid, o_data_pc8, o_data_alures, o_data_memout, o_addr_regdst,
           o_addr_Wrt, o_con_Wloadmux, o_con_Walupc8, o_con_Wmemtoreg, o_con_Wregwrite,
           o_con_FWmemread, o_stall_cnt
  );
endinterface

// File: rtl/memwb_skid_stage.sv
// memwb_skid_stage
//   MEM/WB pipeline stage with valid/ready handshake and a one-entry skid
//   buffer. The incoming PC+4 is turned into the link value (pc4 + LINK_OFF)
//   on entry; all other fields pass through verbatim. Writeback-enabling
//   controls are gated with o_valid so a drained or flushed stage cannot
//   write the register file or trigger forwarding.
//   Ports:
//     i_clk   rising-edge clock
//     i_nrst  asynchronous active-low reset
//     bus     memwb_skid_stage_if.slave: upstream/downstream handshake,
//             payload in/out, flush and stall counter
//   Every output is driven straight from a register (o_ready included), so
//   there is no combinational input-to-output path.
module memwb_skid_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RA_W     = 5,
  parameter int unsigned LMUX_W   = 2,
  parameter int unsigned LINK_OFF = 4,
  parameter int unsigned CNT_W    = 16
) (
  input logic               i_clk,
  input logic               i_nrst,
  memwb_skid_stage_if.slave bus
);

  typedef struct packed {
    logic [DATA_W-1:0] pc8;
    logic [DATA_W-1:0] alures;
    logic [DATA_W-1:0] memout;
    logic [RA_W-1:0]   regdst;
    logic [RA_W-1:0]   rt;
    logic [LMUX_W-1:0] loadmux;
    logic              alupc8;
    logic              memtoreg;
    logic              regwrite;
    logic              fwmemread;
  } payload_t;

  // StEmpty: nothing held; StOne: main only; StFull: main and skid.
  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q;
  payload_t         main_q;
  payload_t         skid_q;
  payload_t         in_pl;
  logic             main_valid_q;
  logic             ready_q;
  logic [CNT_W-1:0] stall_cnt_q;

  logic accept;
  logic retire;
  logic stall;

  assign in_pl.pc8       = bus.i_data_pc4 + DATA_W'(LINK_OFF);
  assign in_pl.alures    = bus.i_data_alures;
  assign in_pl.memout    = bus.i_data_memout;
  assign in_pl.regdst    = bus.i_addr_regdst;
  assign in_pl.rt        = bus.i_addr_Mrt;
  assign in_pl.loadmux   = bus.i_con_Wloadmux;
  assign in_pl.alupc8    = bus.i_con_Walupc8;
  assign in_pl.memtoreg  = bus.i_con_Wmemtoreg;
  assign in_pl.regwrite  = bus.i_con_Wregwrite;
  assign in_pl.fwmemread = bus.i_con_FWmemread;

  assign accept = bus.i_valid & ready_q;
  assign retire = main_valid_q & bus.i_ready;
  // Counts upstream cycles that were offered but refused.
  assign stall  = bus.i_valid & ~ready_q;

  // State, flags, payload and counter all live in one clocked process so the
  // handshake flags can never disagree with the FSM encoding.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q      <= StEmpty;
      main_valid_q <= 1'b0;
      ready_q      <= 1'b1;
      main_q       <= '0;
      skid_q       <= '0;
      stall_cnt_q  <= '0;
    end else begin
      // Stall counter ignores flush; only reset clears it.
      if (stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end

      if (bus.i_flush) begin
        // Payload registers are left alone; the gated controls hide them.
        state_q      <= StEmpty;
        main_valid_q <= 1'b0;
        ready_q      <= 1'b1;
      end else begin
        case (state_q)
          StEmpty: begin
            if (accept) begin
              main_q       <= in_pl;
              main_valid_q <= 1'b1;
              state_q      <= StOne;
            end
          end
          StOne: begin
            if (accept && retire) begin
              main_q <= in_pl;
            end else if (accept) begin
              // Downstream stalled: park the new bundle behind main.
              skid_q  <= in_pl;
              ready_q <= 1'b0;
              state_q <= StFull;
            end else if (retire) begin
              main_valid_q <= 1'b0;
              state_q      <= StEmpty;
            end
          end
          StFull: begin
            if (retire) begin
              main_q  <= skid_q;
              ready_q <= 1'b1;
              state_q <= StOne;
            end
          end
          default: begin
            state_q      <= StEmpty;
            main_valid_q <= 1'b0;
            ready_q      <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.o_ready         = ready_q;
  assign bus.o_valid         = main_valid_q;
  assign bus.o_data_pc8      = main_q.pc8;
  assign bus.o_data_alures   = main_q.alures;
  assign bus.o_data_memout   = main_q.memout;
  assign bus.o_addr_regdst   = main_q.regdst;
  assign bus.o_addr_Wrt      = main_q.rt;
  assign bus.o_con_Wloadmux  = main_q.loadmux;
  assign bus.o_con_Walupc8   = main_q.alupc8;
  assign bus.o_con_Wmemtoreg = main_q.memtoreg;
  assign bus.o_con_Wregwrite = main_q.regwrite & main_valid_q;
  assign bus.o_con_FWmemread = main_q.fwmemread & main_valid_q;
  assign bus.o_stall_cnt     = stall_cnt_q;

endmodule

// File: tb/tb_memwb_skid_stage.sv
module tb_memwb_skid_stage;

  typedef struct packed {
    logic [31:0] pc8;
    logic [31:0] alures;
    logic [31:0] memout;
    logic [4:0]  regdst;
    logic [4:0]  rt;
    logic [1:0]  lmux;
    logic        alupc8;
    logic        memtoreg;
    logic        regwrite;
    logic        fwmemread;
  } pl_t;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  int   total = 0;
  int   bad = 0;
  pl_t  q[$];
  logic [3:0] stall_exp = '0;

  always #5 clk = ~clk;

  memwb_skid_stage_if #(.CNT_W(4)) bus ();

  memwb_skid_stage #(.CNT_W(4)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .bus    (bus)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic set_in(input bit v, input logic [31:0] pc4, input logic [31:0] alu,
                        input logic [4:0] rd, input bit wr);
    bus.i_valid         = v;
    bus.i_data_pc4      = pc4;
    bus.i_data_alures   = alu;
    bus.i_data_memout   = ~pc4;
    bus.i_addr_regdst   = rd;
    bus.i_addr_Mrt      = pc4[6:2];
    bus.i_con_Wloadmux  = pc4[3:2];
    bus.i_con_Walupc8   = pc4[2];
    bus.i_con_Wmemtoreg = pc4[3];
    bus.i_con_Wregwrite = wr;
    bus.i_con_FWmemread = pc4[4];
  endtask

  function automatic pl_t model_in();
    pl_t p;
    p.pc8       = bus.i_data_pc4 + 32'd4;
    p.alures    = bus.i_data_alures;
    p.memout    = bus.i_data_memout;
    p.regdst    = bus.i_addr_regdst;
    p.rt        = bus.i_addr_Mrt;
    p.lmux      = bus.i_con_Wloadmux;
    p.alupc8    = bus.i_con_Walupc8;
    p.memtoreg  = bus.i_con_Wmemtoreg;
    p.regwrite  = bus.i_con_Wregwrite;
    p.fwmemread = bus.i_con_FWmemread;
    return p;
  endfunction

  function automatic pl_t sample_out();
    pl_t p;
    p.pc8       = bus.o_data_pc8;
    p.alures    = bus.o_data_alures;
    p.memout    = bus.o_data_memout;
    p.regdst    = bus.o_addr_regdst;
    p.rt        = bus.o_addr_Wrt;
    p.lmux      = bus.o_con_Wloadmux;
    p.alupc8    = bus.o_con_Walupc8;
    p.memtoreg  = bus.o_con_Wmemtoreg;
    p.regwrite  = bus.o_con_Wregwrite;
    p.fwmemread = bus.o_con_FWmemread;
    return p;
  endfunction

  // Advances one clock. The model's own occupancy decides acceptance; the
  // scoreboard pops on a DUT retire and pushes on a modelled accept.
  task automatic cycle(output bit acc, output bit ret, output pl_t got, output pl_t exp);
    bit rdy_m;
    rdy_m = (q.size() < 2);
    acc   = bus.i_valid && rdy_m && !bus.i_flush;
    ret   = bus.o_valid && bus.i_ready;
    got   = sample_out();
    exp   = '0;
    if (ret) begin
      if (q.size() > 0) exp = q.pop_front();
      else exp = ~got;
    end
    if (bus.i_valid && !rdy_m && stall_exp != 4'hF) stall_exp = stall_exp + 4'd1;
    if (bus.i_flush) q.delete();
    else if (acc) q.push_back(model_in());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.i_ready = 1'b0;
    bus.i_flush = 1'b0;
    q.delete();
    stall_exp = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", bus.o_ready); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus.o_valid); end
    total++; if (bus.o_data_pc8 !== 32'h0) begin bad++; $display("FAIL reset_pc8 got=%h exp=0", bus.o_data_pc8); end
    total++; if (bus.o_data_alures !== 32'h0) begin bad++; $display("FAIL reset_alures got=%h exp=0", bus.o_data_alures); end
    total++; if (bus.o_addr_regdst !== 5'h0) begin bad++; $display("FAIL reset_regdst got=%h exp=0", bus.o_addr_regdst); end
    total++; if (bus.o_con_Wregwrite !== 1'b0) begin bad++; $display("FAIL reset_wregwrite got=%b exp=0", bus.o_con_Wregwrite); end
    total++; if (bus.o_con_FWmemread !== 1'b0) begin bad++; $display("FAIL reset_fwmemread got=%b exp=0", bus.o_con_FWmemread); end
    total++; if (bus.o_stall_cnt !== 4'h0) begin bad++; $display("FAIL reset_stall got=%h exp=0", bus.o_stall_cnt); end
  endtask

  task automatic test_single();
    bit acc, ret; pl_t got, exp;
    do_reset();
    bus.i_ready = 1'b1;
    set_in(1'b1, 32'h100, 32'hA5, 5'd3, 1'b1);
    cycle(acc, ret, got, exp);
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b exp=1", bus.o_valid); end
    total++; if (bus.o_data_pc8 !== 32'h104) begin bad++; $display("FAIL single_pc8 got=%h exp=104", bus.o_data_pc8); end
    total++; if (bus.o_addr_regdst !== 5'd3) begin bad++; $display("FAIL single_regdst got=%0d exp=3", bus.o_addr_regdst); end
    total++; if (bus.o_con_Wregwrite !== 1'b1) begin bad++; $display("FAIL single_wregwrite got=%b exp=1", bus.o_con_Wregwrite); end
    cycle(acc, ret, got, exp);
    total++; if (!ret || got !== exp) begin bad++; $display("FAIL single_data ret=%b got=%h exp=%h", ret, got, exp); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%b exp=0", bus.o_valid); end
    total++; if (bus.o_con_Wregwrite !== 1'b0) begin bad++; $display("FAIL single_wregwrite_drop got=%b exp=0", bus.o_con_Wregwrite); end
  endtask

  task automatic test_backpressure();
    bit acc, ret; pl_t got, exp;
    int idx = 0, nret = 0;
    do_reset();
    for (int cyc = 0; cyc < 60; cyc++) begin
      bus.i_ready = (cyc >= 5);
      set_in(idx < 4, 32'(idx * 4), 32'(idx), 5'(idx + 1), 1'b1);
      cycle(acc, ret, got, exp);
      if (acc) idx++;
      if (acc && idx == 2) begin
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low got=%b exp=0", bus.o_ready); end
      end
      if (ret) begin
        total++;
        if (got !== exp || got.pc8 !== 32'(4 * (nret + 1))) begin
          bad++; $display("FAIL bp_order n=%0d got=%h exp=%h", nret, got, exp);
        end
        nret++;
      end
      if (idx == 4 && q.size() == 0) break;
    end
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    total++; if (nret != 4) begin bad++; $display("FAIL bp_count got=%0d exp=4", nret); end
    total++; if (bus.o_stall_cnt !== 4'd4) begin bad++; $display("FAIL bp_stall got=%0d exp=4", bus.o_stall_cnt); end
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", bus.o_valid); end
  endtask

  task automatic test_flush();
    bit acc, ret; pl_t got, exp;
    bit seen = 0;
    do_reset();
    set_in(1'b1, 32'h10, 32'h1, 5'd1, 1'b1); cycle(acc, ret, got, exp);
    set_in(1'b1, 32'h14, 32'h2, 5'd2, 1'b1); cycle(acc, ret, got, exp);
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL flush_full got=%b exp=0", bus.o_ready); end
    set_in(1'b1, 32'h500, 32'h5, 5'd5, 1'b1);
    bus.i_flush = 1'b1; cycle(acc, ret, got, exp); bus.i_flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", bus.o_valid); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", bus.o_ready); end
    total++; if (bus.o_con_FWmemread !== 1'b0) begin bad++; $display("FAIL flush_fwmemread got=%b exp=0", bus.o_con_FWmemread); end
    set_in(1'b1, 32'h600, 32'h6, 5'd6, 1'b1); cycle(acc, ret, got, exp);
    set_in(1'b1, 32'h700, 32'h7, 5'd7, 1'b1);
    bus.i_flush = 1'b1; cycle(acc, ret, got, exp); bus.i_flush = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL flush_accepted got=%b exp=0", bus.o_valid); end
    bus.i_ready = 1'b1;
    set_in(1'b1, 32'h800, 32'h8, 5'd8, 1'b1);
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(acc, ret, got, exp);
      if (acc) set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
      if (ret) begin
        seen = 1;
        total++;
        if (got !== exp || got.pc8 !== 32'h804) begin
          bad++; $display("FAIL flush_next got=%h exp=%h", got, exp);
        end
      end
    end
    total++; if (!seen) begin bad++; $display("FAIL flush_timeout got=none exp=pc8 804"); end
  endtask

  task automatic test_wrap();
    bit acc, ret; pl_t got, exp;
    do_reset();
    bus.i_ready = 1'b1;
    set_in(1'b1, 32'hFFFF_FFFE, 32'h0, 5'd9, 1'b0);
    cycle(acc, ret, got, exp);
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    total++; if (bus.o_data_pc8 !== 32'h0000_0002) begin bad++; $display("FAIL wrap_pc8 got=%h exp=00000002", bus.o_data_pc8); end
    cycle(acc, ret, got, exp);
    total++; if (!ret || got !== exp) begin bad++; $display("FAIL wrap_data ret=%b got=%h exp=%h", ret, got, exp); end
  endtask

  task automatic test_saturation();
    bit acc, ret; pl_t got, exp;
    int nret = 0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_in(1'b1, 32'(i * 4 + 32'h40), 32'(i), 5'(i), 1'b1);
      cycle(acc, ret, got, exp);
    end
    total++; if (bus.o_stall_cnt !== 4'd5) begin bad++; $display("FAIL sat_mid got=%0d exp=5", bus.o_stall_cnt); end
    for (int i = 0; i < 15; i++) cycle(acc, ret, got, exp);
    total++; if (bus.o_stall_cnt !== 4'hF) begin bad++; $display("FAIL sat_top got=%h exp=f", bus.o_stall_cnt); end
    total++; if (bus.o_stall_cnt !== stall_exp) begin bad++; $display("FAIL sat_model got=%h exp=%h", bus.o_stall_cnt, stall_exp); end
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(acc, ret, got, exp);
      if (ret) begin
        nret++; total++;
        if (got !== exp) begin bad++; $display("FAIL sat_drain got=%h exp=%h", got, exp); end
      end
    end
    total++; if (nret != 2) begin bad++; $display("FAIL sat_count got=%0d exp=2", nret); end
  endtask

  task automatic test_async_reset();
    bit acc, ret; pl_t got, exp;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'(32'h80 + i * 4), 32'(i), 5'd4, 1'b1);
      cycle(acc, ret, got, exp);
    end
    total++; if (bus.o_con_Wregwrite !== 1'b1) begin bad++; $display("FAIL ar_pre got=%b exp=1", bus.o_con_Wregwrite); end
    #3;
    nrst = 1'b0;
    #1;
    total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b exp=0", bus.o_valid); end
    total++; if (bus.o_con_Wregwrite !== 1'b0) begin bad++; $display("FAIL ar_wregwrite got=%b exp=0", bus.o_con_Wregwrite); end
    total++; if (bus.o_stall_cnt !== 4'h0) begin bad++; $display("FAIL ar_stall got=%h exp=0", bus.o_stall_cnt); end
    total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b exp=1", bus.o_ready); end
    q.delete();
    stall_exp = '0;
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    bit acc, ret; pl_t got, exp;
    int idx = 0, nret = 0, cyc = 0;
    do_reset();
    bus.i_ready = 1'b1;
    while (nret < 10 && cyc < 50) begin
      set_in(idx < 10, $urandom, $urandom, 5'($urandom), 1'($urandom));
      cycle(acc, ret, got, exp);
      cyc++;
      if (acc) idx++;
      if (ret) begin
        nret++; total++;
        if (got !== exp) begin bad++; $display("FAIL b2b_stream got=%h exp=%h", got, exp); end
      end
    end
    total++; if (cyc != 11) begin bad++; $display("FAIL b2b_throughput got=%0d exp=11", cyc); end
    idx = 0; nret = 0;
    for (int c = 0; c < 500 && nret < 30; c++) begin
      set_in(idx < 30 && $urandom_range(0, 3) != 0, $urandom, $urandom, 5'($urandom), 1'($urandom));
      bus.i_ready = ($urandom_range(0, 2) != 0);
      total++;
      if (bus.o_ready !== (q.size() < 2) || bus.o_valid !== (q.size() != 0)) begin
        bad++;
        $display("FAIL rand_flags got=%b%b exp=%b%b", bus.o_ready, bus.o_valid,
                 q.size() < 2, q.size() != 0);
      end
      cycle(acc, ret, got, exp);
      if (acc) idx++;
      if (ret) begin
        nret++; total++;
        if (got !== exp) begin bad++; $display("FAIL rand_data got=%h exp=%h", got, exp); end
      end
    end
    set_in(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
    total++; if (nret != 30) begin bad++; $display("FAIL rand_count got=%0d exp=30", nret); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_flush();
    test_wrap();
    test_saturation();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memwb_skid_stage.md
# memwb_skid_stage

Parametrised MEM/WB pipeline stage with a valid/ready handshake and a one-entry skid buffer. It takes the memory-stage bundle (PC+4, ALU result, load data, destination register, writeback controls and forwarding tags) and presents it to writeback one cycle later. It computes the link value `pc4 + LINK_OFF` on entry. Unlike a plain enable-less pipeline register, it supports downstream back-pressure, synchronous flush, valid-gated writeback/forwarding controls, and a stall counter.

## Interface
- DATA_W, 32, width of PC, ALU result and memory data
- RA_W, 5, register address width
- LMUX_W, 2, load-mux control width
- LINK_OFF, 4, constant added to i_data_pc4 to form the link value
- CNT_W, 16, stall counter width
- i_clk  in  1  clock, rising edge
- i_nrst  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous flush, discards all held entries
- i_valid  in  1  upstream bundle valid
- o_ready  out  1  stage can accept (registered, equals ~skid_valid)
- i_data_pc4  in  DATA_W  PC+4 of the instruction
- i_data_alures, i_data_memout  in  DATA_W  ALU result, load data
- i_addr_regdst, i_addr_Mrt  in  RA_W  destination reg, rt for forwarding
- i_con_Wloadmux  in  LMUX_W; i_con_Walupc8, i_con_Wmemtoreg, i_con_Wregwrite, i_con_FWmemread  in  1 each
- o_valid  out  1  output bundle valid
- i_ready  in  1  writeback accepts bundle
- o_data_pc8, o_data_alures, o_data_memout  out  DATA_W
- o_addr_regdst, o_addr_Wrt  out  RA_W
- o_con_Wloadmux  out  LMUX_W; o_con_Walupc8, o_con_Wmemtoreg  out  1
- o_con_Wregwrite, o_con_FWmemread  out  1  gated with o_valid
- o_stall_cnt  out  CNT_W  saturating count of back-pressured input cycles

## Operation
- Accept = i_valid & o_ready. Retire = o_valid & i_ready.
- Storage:
  - Main register, drives all outputs.
  - Skid register, same payload.
  - main_valid and skid_valid flags; o_valid = main_valid.
- Entry payload stores i_data_pc4 + LINK_OFF, modulo 2^DATA_W, in place of pc4. All other fields are stored verbatim.
- States and transitions:
  - EMPTY (main_valid=0, skid_valid=0):
    - accept -> ONE, main <= in
  - ONE (main_valid=1, skid_valid=0):
    - accept & retire -> ONE, main <= in
    - accept only -> FULL, skid <= in
    - retire only -> EMPTY
    - neither -> ONE, hold
  - FULL (main_valid=1, skid_valid=1), o_ready=0:
    - retire -> ONE, main <= skid
    - no retire -> FULL, hold
- Flush:
  - i_flush=1 forces EMPTY next cycle regardless of accept/retire. Any input accepted in that cycle is discarded.
  - Payload registers hold their values; outputs other than the gated controls are then don't-care.
- Gated controls:
  - o_con_Wregwrite = main_Wregwrite & main_valid.
  - o_con_FWmemread = main_FWmemread & main_valid.
- Stall counter:
  - Increments when i_valid & ~o_ready, saturating at all-ones.
  - Unaffected by flush; cleared only by reset.
- Reset:
  - All flags and payload registers are 0; counter is 0. State is EMPTY, o_ready=1, o_valid=0.
  - Every output reads 0 except o_ready.

## Timing
- Latency: an accept in EMPTY, or an accept+retire in ONE, gives o_valid=1 with that payload on the next edge (1 cycle).
- Throughput: 1 bundle/cycle while i_ready=1. There are no bubbles through ONE.
- o_ready is a register output. There is no combinational path from i_ready to o_ready, or from any input to any output.
- After i_ready falls, the stage absorbs exactly one extra bundle (the skid), then deasserts o_ready the following cycle.
- Reset is asynchronous assert with synchronous deassert externally. A reset mid-transfer drops both entries immediately.
- Order is preserved: the skid entry always retires after the main entry.

## Test plan
- Reset then single transfer: pulse i_nrst low, then present pc4=0x100, alures=0xA5, regdst=3, Wregwrite=1, i_valid=1, i_ready=1 for one cycle -> next cycle o_valid=1, o_data_pc8=0x104, o_addr_regdst=3, o_con_Wregwrite=1; the cycle after, o_valid=0 and o_con_Wregwrite=0.
- Back-pressure/skid: stream pc4=0x0,0x4,0x8,0xC with i_ready=0 from cycle 1 -> o_ready falls after the 2nd accept; o_stall_cnt counts the held cycles; on i_ready=1, outputs pc8=0x4,0x8,0xC,0x10 appear in order with no loss or duplicate.
- Flush while FULL: fill both entries, assert i_flush with i_valid=1 -> next cycle o_valid=0, o_ready=1, o_con_FWmemread=0; the input offered in the flush cycle never appears.
- Wrap: i_data_pc4=0xFFFF_FFFE, LINK_OFF=4 -> o_data_pc8=0x0000_0002.
- Counter saturation: with CNT_W=4, hold i_valid=1 and o_ready=0 for 20 cycles -> o_stall_cnt stops at 0xF.
- Async reset mid-operation: assert i_nrst low while FULL, between clock edges -> o_valid, o_con_Wregwrite and o_stall_cnt go to 0 immediately, and o_ready goes to 1.
